// File: rtl/byte_seq_engine.sv
// Byte-code sequencer: on a trigger byte it fetches opcodes from a synchronous-read
// memory, runs a small register machine and streams bytes out over a valid/ready port.
module byte_seq_engine #(
   parameter int          ADDR_W     = 9,
   parameter int unsigned START_ADDR = 0,
   parameter logic [7:0]  TRIG       = 8'h61,
   parameter logic [15:0] MAX_STEPS  = 16'd0
) (
   input  logic              clk,
   input  logic              resetq,
   input  logic              start_valid,
   input  logic [7:0]        start_data,
   output logic              start_ready,
   input  logic              abort,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err
);

   typedef enum logic [2:0] {S_IDLE, S_OP, S_ARG1, S_ARG2, S_SEND, S_LOAD} state_e;

   localparam logic [ADDR_W-1:0] START_PTR = ADDR_W'(START_ADDR);

   state_e            state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [7:0]        op_q;
   logic [7:0]        lo_q;
   logic [7:0]        regs_q [4];
   logic [15:0]       steps_q;
   logic              tx_valid_q;
   logic [7:0]        tx_data_q;
   logic              done_q;
   logic [1:0]        err_q;

   logic [ADDR_W-1:0] ptr_inc;
   logic [ADDR_W-1:0] jmp_tgt;
   logic              jmp_take;
   logic              watchdog;
   logic [1:0]        op_x;
   logic [1:0]        op_y;

   assign ptr_inc  = ptr_q + ADDR_W'(1);
   assign jmp_tgt  = ADDR_W'({mem_rdata, lo_q});
   assign jmp_take = (op_q == 8'h01) || (regs_q[op_q[1:0]] != 8'h00);
   assign watchdog = (MAX_STEPS != 16'd0) && (steps_q == MAX_STEPS);
   assign op_x     = mem_rdata[3:2];
   assign op_y     = mem_rdata[1:0];

   // Address of the byte that must be on mem_rdata in the following cycle.
   always_comb begin
      // NOTE: default assignment first so every path drives mem_addr and no latch is inferred.
      mem_addr = ptr_inc;
      unique case (state_q)
         S_IDLE: mem_addr = START_PTR;
         S_OP: begin
            if (mem_rdata[7:4] == 4'hC) begin
               mem_addr = ADDR_W'({regs_q[{op_y[1], 1'b1}], regs_q[{op_y[1], 1'b0}]});
            end
         end
         S_ARG2: begin
            if (jmp_take) mem_addr = jmp_tgt;
         end
         S_SEND, S_LOAD: mem_addr = ptr_q;
         default: mem_addr = ptr_inc;
      endcase
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         op_q       <= '0;
         lo_q       <= '0;
         steps_q    <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         done_q     <= 1'b0;
         err_q      <= 2'b00;
         // NOTE: the four-entry register file is plain flops, so it is cleared on reset like any other state.
         for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values.
         done_q <= 1'b0;
         if (abort && (state_q != S_IDLE)) begin
            state_q    <= S_IDLE;
            tx_valid_q <= 1'b0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (start_valid && (start_data == TRIG)) begin
                     state_q <= S_OP;
                     ptr_q   <= START_PTR;
                     err_q   <= 2'b00;
                     steps_q <= '0;
                  end
               end
               S_OP: begin
                  if (watchdog) begin
                     state_q <= S_IDLE;
                     err_q   <= 2'b10;
                  end else begin
                     ptr_q   <= ptr_inc;
                     steps_q <= steps_q + 16'd1;
                     op_q    <= mem_rdata;
                     casez (mem_rdata)
                        8'h00: begin
                           state_q <= S_IDLE;
                           done_q  <= 1'b1;
                        end
                        8'h01, 8'b0001_00??, 8'b0000_01??: state_q <= S_ARG1;
                        8'b0000_10??: begin
                           tx_data_q  <= regs_q[op_y];
                           tx_valid_q <= 1'b1;
                           state_q    <= S_SEND;
                        end
                        8'b0000_11??: regs_q[op_y] <= regs_q[op_y] - 8'd1;
                        8'b0001_10??: regs_q[op_y] <= regs_q[op_y] + 8'd1;
                        8'b1000_????: regs_q[op_x] <= regs_q[op_x] + regs_q[op_y];
                        8'b1100_????: state_q <= S_LOAD;
                        default: begin
                           state_q <= S_IDLE;
                           err_q   <= 2'b01;
                        end
                     endcase
                  end
               end
               S_ARG1: begin
                  ptr_q <= ptr_inc;
                  if (op_q[7:2] == 6'b0000_01) begin
                     regs_q[op_q[1:0]] <= mem_rdata;
                     state_q           <= S_OP;
                  end else begin
                     lo_q    <= mem_rdata;
                     state_q <= S_ARG2;
                  end
               end
               S_ARG2: begin
                  ptr_q   <= jmp_take ? jmp_tgt : ptr_inc;
                  state_q <= S_OP;
               end
               S_SEND: begin
                  if (tx_ready) begin
                     tx_valid_q <= 1'b0;
                     state_q    <= S_OP;
                  end
               end
               S_LOAD: begin
                  regs_q[op_q[3:2]] <= mem_rdata;
                  state_q           <= S_OP;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign start_ready = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign tx_valid    = tx_valid_q;
   assign tx_data     = tx_data_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_byte_seq_engine.sv
// Scoreboard bench for byte_seq_engine: an instruction-level interpreter predicts the
// byte stream; a negedge monitor pops and compares every transfer.
module tb_byte_seq_engine;

   localparam int         AW   = 10;
   localparam int         MSZ  = 1024;
   localparam logic [7:0] TRIG = 8'h61;

   logic          clk = 1'b0;
   logic          resetq;
   logic          start_valid;
   logic [7:0]    start_data;
   logic          start_ready;
   logic          abort;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata;
   logic          tx_valid;
   logic [7:0]    tx_data;
   logic          tx_ready;
   logic          busy;
   logic          done;
   logic [1:0]    err;

   logic          wd_start_valid;
   logic [7:0]    wd_start_data;
   logic          wd_start_ready;
   logic          wd_abort;
   logic [8:0]    wd_addr;
   logic [7:0]    wd_rdata;
   logic          wd_tx_valid;
   logic [7:0]    wd_tx_data;
   logic          wd_tx_ready;
   logic          wd_busy;
   logic          wd_done;
   logic [1:0]    wd_err;

   logic [7:0] mem    [MSZ];
   logic [7:0] wd_mem [512];
   logic [7:0] m_regs [4];
   logic [7:0] exp_tx [$];

   int n_checks    = 0;
   int n_err       = 0;
   int done_cnt    = 0;
   int wd_done_cnt = 0;

   byte_seq_engine #(.ADDR_W(AW)) dut (
      .clk(clk), .resetq(resetq),
      .start_valid(start_valid), .start_data(start_data), .start_ready(start_ready),
      .abort(abort), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .busy(busy), .done(done), .err(err)
   );

   byte_seq_engine #(.ADDR_W(9), .START_ADDR(32'h20), .MAX_STEPS(16'd5)) dut_wd (
      .clk(clk), .resetq(resetq),
      .start_valid(wd_start_valid), .start_data(wd_start_data), .start_ready(wd_start_ready),
      .abort(wd_abort), .mem_addr(wd_addr), .mem_rdata(wd_rdata),
      .tx_valid(wd_tx_valid), .tx_data(wd_tx_data), .tx_ready(wd_tx_ready),
      .busy(wd_busy), .done(wd_done), .err(wd_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_rdata <= mem[mem_addr];
   always @(posedge clk) wd_rdata  <= wd_mem[wd_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: inputs change just after posedge, so negedge values are what the next edge sees.
   always @(negedge clk) begin : monitor
      logic [7:0] e;
      if (resetq) begin
         if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL tx_extra: got 0x%02h, expected no transfer", tx_data);
            end else begin
               e = exp_tx.pop_front();
               check("tx_data", tx_data, e);
            end
         end
         if (done)    done_cnt++;
         if (wd_done) wd_done_cnt++;
      end
   end

   // Instruction-level interpreter over the bench memory; kind: 0 halt, 1 illegal, 2 runaway.
   task automatic model_run(output int kind);
      int         pc;
      int         steps;
      int         base;
      logic [7:0] op;
      logic [7:0] lo;
      logic [7:0] hi;
      pc = 0;
      steps = 0;
      kind = -1;
      while (kind < 0) begin
         op = mem[pc];
         pc = (pc + 1) % MSZ;
         steps++;
         if (op == 8'h00) begin
            kind = 0;
         end else if (op == 8'h01 || op inside {[8'h10:8'h13]}) begin
            lo = mem[pc];
            hi = mem[(pc + 1) % MSZ];
            pc = (pc + 2) % MSZ;
            if (op == 8'h01 || m_regs[op[1:0]] != 8'h00) pc = int'({hi, lo}) % MSZ;
         end else if (op inside {[8'h04:8'h07]}) begin
            m_regs[op[1:0]] = mem[pc];
            pc = (pc + 1) % MSZ;
         end else if (op inside {[8'h08:8'h0B]}) begin
            exp_tx.push_back(m_regs[op[1:0]]);
         end else if (op inside {[8'h0C:8'h0F]}) begin
            m_regs[op[1:0]] = m_regs[op[1:0]] - 8'd1;
         end else if (op inside {[8'h18:8'h1B]}) begin
            m_regs[op[1:0]] = m_regs[op[1:0]] + 8'd1;
         end else if (op inside {[8'h80:8'h8F]}) begin
            m_regs[op[3:2]] = m_regs[op[3:2]] + m_regs[op[1:0]];
         end else if (op inside {[8'hC0:8'hCF]}) begin
            base = op[1] ? 2 : 0;
            m_regs[op[3:2]] = mem[(int'(m_regs[base + 1]) * 256 + int'(m_regs[base])) % MSZ];
         end else begin
            kind = 1;
         end
         if (kind < 0 && steps > 4000) kind = 2;
      end
   endtask

   task automatic load(input int n, input logic [63:0] bytes);
      for (int i = 0; i < MSZ; i++) mem[i] = 8'hFF;
      for (int i = 0; i < n; i++) mem[i] = bytes[8*(n-1-i) +: 8];
   endtask

   task automatic gen_random_prog();
      int         p;
      int         sel;
      int         tgt;
      logic [7:0] n;
      p = 0;
      for (int i = 0; i < MSZ; i++) mem[i] = 8'($urandom);
      for (int k = 0; k < 12; k++) begin
         sel = $urandom_range(0, 7);
         n   = 8'($urandom_range(0, 3));
         tgt = p + 4;
         case (sel)
            0: begin mem[p] = 8'h04 | n; mem[p+1] = 8'($urandom); p += 2; end
            1: begin mem[p] = 8'h08 | n; p += 1; end
            2: begin mem[p] = 8'h0C | n; p += 1; end
            3: begin mem[p] = 8'h18 | n; p += 1; end
            4: begin mem[p] = 8'h80 | 8'($urandom_range(0, 15)); p += 1; end
            5: begin mem[p] = 8'hC0 | 8'($urandom_range(0, 15)); p += 1; end
            6: begin
               mem[p] = 8'h01; mem[p+1] = 8'(tgt); mem[p+2] = 8'(tgt >> 8);
               mem[p+3] = 8'h08 | 8'($urandom_range(0, 3)); p += 4;
            end
            default: begin
               mem[p] = 8'h10 | n; mem[p+1] = 8'(tgt); mem[p+2] = 8'(tgt >> 8);
               mem[p+3] = 8'h08 | 8'($urandom_range(0, 3)); p += 4;
            end
         endcase
      end
      mem[p] = 8'h00;
   endtask

   task automatic trigger(input logic [7:0] b, input bit with_abort);
      @(posedge clk); #1;
      start_valid = 1'b1;
      start_data  = b;
      abort       = with_abort;
      @(posedge clk); #1;
      start_valid = 1'b0;
      abort       = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input bit rand_ready, output int sr_bad);
      int cyc;
      sr_bad = 0;
      for (cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk);
         if (!busy) break;
         if (start_ready) sr_bad++;
         @(posedge clk); #1;
         if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
      end
      if (cyc >= budget) begin
         n_checks++;
         n_err++;
         $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", budget);
         @(posedge clk); #1; abort = 1'b1;
         @(posedge clk); #1; abort = 1'b0;
      end
      @(posedge clk); #1;
      tx_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_tx_valid(input string name);
      int i;
      for (i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx_valid) break;
      end
      check({name, "_tx_valid_seen"}, 32'(i < 50), 32'd1);
   endtask

   task automatic finish_run(input string name, input logic [1:0] exp_err, input int exp_done);
      check({name, "_err"}, 32'(err), 32'(exp_err));
      check({name, "_done"}, done_cnt, exp_done);
      check({name, "_pending"}, exp_tx.size(), 0);
      exp_tx.delete();
   endtask

   task automatic run_prog(input string name, input bit rand_ready, input bit chk_sr,
                           input bit with_abort);
      int kind;
      int sr_bad;
      model_run(kind);
      done_cnt = 0;
      tx_ready = 1'b1;
      trigger(TRIG, with_abort);
      wait_idle(3000, rand_ready, sr_bad);
      if (chk_sr) check({name, "_start_ready_low"}, sr_bad, 0);
      finish_run(name, (kind == 1) ? 2'b01 : 2'b00, (kind == 0) ? 1 : 0);
   endtask

   initial begin
      int         kind;
      int         sr_bad;
      int         cyc;
      int         bad;
      logic [7:0] ld_val;

      resetq         = 1'b0;
      start_valid    = 1'b0;
      start_data     = 8'h00;
      abort          = 1'b0;
      tx_ready       = 1'b1;
      wd_start_valid = 1'b0;
      wd_start_data  = TRIG;
      wd_abort       = 1'b0;
      wd_tx_ready    = 1'b1;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      for (int i = 0; i < 512; i++) wd_mem[i] = 8'hFF;
      load(1, 64'h00);

      repeat (3) @(negedge clk);
      check("rst_start_ready", 32'(start_ready), 32'd1);
      check("rst_busy",        32'(busy),        32'd0);
      check("rst_tx_valid",    32'(tx_valid),    32'd0);
      check("rst_tx_data",     32'(tx_data),     32'd0);
      check("rst_done",        32'(done),        32'd0);
      check("rst_err",         32'(err),         32'd0);
      check("rst_mem_addr",    32'(mem_addr),    32'd0);
      @(posedge clk); #1;
      resetq = 1'b1;

      // A non-trigger byte is consumed and ignored.
      trigger(8'h62, 1'b0);
      @(negedge clk);
      check("nontrig_busy", 32'(busy), 32'd0);

      // Watchdog instance: JUMP-to-self at START_ADDR 0x20, limit 5 instructions.
      wd_mem[32] = 8'h01; wd_mem[33] = 8'h20; wd_mem[34] = 8'h00;
      @(posedge clk); #1; wd_start_valid = 1'b1;
      @(posedge clk); #1; wd_start_valid = 1'b0;
      cyc = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!wd_busy) break;
         cyc++;
      end
      check("wd_busy_cycles", cyc, 32'd16);
      check("wd_err",         32'(wd_err), 32'd2);
      check("wd_done",        wd_done_cnt, 32'd0);
      check("wd_tx_valid",    32'(wd_tx_valid), 32'd0);

      // Single MOVI/SEND/HALT; abort held during the trigger cycle must not block the start.
      load(4, 64'h0441_0800);
      run_prog("basic", 1'b0, 1'b1, 1'b1);

      // Countdown loop 3,2,1 using DEC and JNZ back to the SEND.
      load(8, 64'h0403_080C_1002_0000);
      run_prog("countdown", 1'b0, 1'b1, 1'b0);

      // Back-pressure: tx_ready low for 10 cycles while the byte waits.
      load(4, 64'h045A_0800);
      model_run(kind);
      done_cnt = 0;
      tx_ready = 1'b0;
      trigger(TRIG, 1'b0);
      wait_tx_valid("hold");
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (!tx_valid || tx_data !== 8'h5A) bad++;
         @(negedge clk);
      end
      check("hold_stable", bad, 0);
      @(posedge clk); #1;
      tx_ready = 1'b1;
      wait_idle(200, 1'b0, sr_bad);
      finish_run("hold", 2'b00, 1);

      // LD r2,[r0:r1] with r0=0x34, r1=0x02, then SEND r2 from the following opcode.
      load(7, 64'h0434_0502_C80A_00);
      ld_val = 8'($urandom_range(1, 254));
      mem[12'h234] = ld_val;
      run_prog("load", 1'b0, 1'b0, 1'b0);
      check("load_model_value", 32'(m_regs[2]), 32'(ld_val));

      // Illegal opcode after one transfer.
      load(4, 64'h0411_08FF);
      run_prog("illegal", 1'b0, 1'b0, 1'b0);

      for (int r = 0; r < 8; r++) begin
         gen_random_prog();
         run_prog($sformatf("rand%0d", r), 1'b1, 1'b1, 1'b0);
      end

      // Abort while a SEND waits on tx_ready.
      load(4, 64'h0477_0800);
      done_cnt = 0;
      tx_ready = 1'b0;
      trigger(TRIG, 1'b0);
      wait_tx_valid("abort");
      @(posedge clk); #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      @(negedge clk);
      check("abort_tx_valid", 32'(tx_valid), 32'd0);
      check("abort_busy",     32'(busy),     32'd0);
      check("abort_err",      32'(err),      32'd0);
      @(posedge clk); #1; tx_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_done", done_cnt, 32'd0);
      m_regs[0] = 8'h77;

      // Asynchronous reset in the middle of a SEND.
      load(4, 64'h0499_0900);
      tx_ready = 1'b0;
      trigger(TRIG, 1'b0);
      wait_tx_valid("rstsend");
      #2 resetq = 1'b0;
      #1;
      check("rstsend_tx_valid",    32'(tx_valid),    32'd0);
      check("rstsend_tx_data",     32'(tx_data),     32'd0);
      check("rstsend_start_ready", 32'(start_ready), 32'd1);
      check("rstsend_busy",        32'(busy),        32'd0);
      repeat (2) @(posedge clk);
      #1 resetq = 1'b1;
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;

      // Registers must read back as zero after reset.
      load(3, 64'h090B_00);
      run_prog("post_reset", 1'b0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
